// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and helpers for the byte-serialising memory access unit.
package mem_access_unit_pkg;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_BYTE = 2'd1;
    localparam logic [1:0] SZ_HALF = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic [2:0] byte_count(input logic [1:0] size);
        case (size)
            SZ_WORD: byte_count = 3'd4;
            SZ_HALF: byte_count = 3'd2;
            default: byte_count = 3'd1;
        endcase
    endfunction

    // Accesses rejected up front, before any memory traffic is generated.
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_WORD: access_err = (addr_lo != 2'd0);
            SZ_HALF: access_err = addr_lo[0];
            SZ_RSVD: access_err = 1'b1;
            default: access_err = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Zero/sign extension of assembled little-endian load bytes; shared with writeback.
module mem_access_unit_load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] result_o
);

    always_comb begin
        result_o = data_i;
        case (size_i)
            SZ_BYTE: result_o = {{24{signed_i & data_i[7]}}, data_i[7:0]};
            SZ_HALF: result_o = {{16{signed_i & data_i[15]}}, data_i[15:0]};
            default: result_o = data_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Serialises one CPU load/store into byte requests on a req/ack bus and returns one response.
// Optional MEM_ACCESS_TRACE_EN prints a line for every successful store.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [31:0]       req_pc,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    state_e            state_q;
    logic [31:0]       addr_q, wdata_q, pc_q, bytes_q, bytes_d, ext_result;
    logic [1:0]        size_q, k_q, k_inc;
    logic              signed_q, write_q, last_byte;
    logic [WAIT_W-1:0] wait_q;
    logic [ADDR_W-1:0] next_addr, mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              rsp_valid_q, rsp_err_q, mem_req_q, mem_we_q;
    logic [31:0]       rsp_rdata_q;

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    assign k_inc     = k_q + 2'd1;
    assign last_byte = ({1'b0, k_q} == (byte_count(size_q) - 3'd1));
    assign next_addr = addr_q[ADDR_W-1:0] + ADDR_W'({1'b0, k_q} + 3'd1);

    // Include the byte arriving this cycle so the final result can be registered on the last ack.
    always_comb begin
        bytes_d = bytes_q;
        bytes_d[{k_q, 3'b000} +: 8] = mem_rdata;
    end

    mem_access_unit_load_extend u_load_extend (
        .data_i   (bytes_d),
        .size_i   (size_q),
        .signed_i (signed_q),
        .result_o (ext_result)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            pc_q        <= '0;
            size_q      <= SZ_WORD;
            signed_q    <= 1'b0;
            write_q     <= 1'b0;
            k_q         <= '0;
            wait_q      <= '0;
            bytes_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        pc_q     <= req_pc;
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        write_q  <= req_write;
                        k_q      <= '0;
                        wait_q   <= '0;
                        bytes_q  <= '0;
                        if (access_err(req_size, req_addr[1:0])) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else begin
                            state_q     <= ST_XFER;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= req_write;
                            mem_addr_q  <= req_addr[ADDR_W-1:0];
                            mem_wdata_q <= req_wdata[7:0];
                        end
                    end
                end
                ST_XFER: begin
                    if (mem_ack) begin
                        wait_q <= '0;
                        if (!write_q) bytes_q <= bytes_d;
                        if (last_byte) begin
                            state_q     <= ST_RESP;
                            mem_req_q   <= 1'b0;
                            mem_we_q    <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_rdata_q <= write_q ? 32'd0 : ext_result;
                        end else begin
                            k_q         <= k_inc;
                            mem_addr_q  <= next_addr;
                            mem_wdata_q <= wdata_q[{k_inc, 3'b000} +: 8];
                        end
                    end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
                        state_q     <= ST_RESP;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    state_q     <= ST_IDLE;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef MEM_ACCESS_TRACE_EN
    logic [31:0] trace_data;
    always_comb begin
        case (size_q)
            SZ_BYTE: trace_data = {24'd0, wdata_q[7:0]};
            SZ_HALF: trace_data = {16'd0, wdata_q[15:0]};
            default: trace_data = wdata_q;
        endcase
    end

    always @(posedge clk) begin
        if (rst && state_q == ST_XFER && mem_ack && last_byte && write_q)
            $display("%d@%h: *%h <= %h", $time, pc_q, addr_q, trace_data);
    end
`else
    // Without tracing, the PC and the ignored upper address bits have no consumer.
    logic unused_trace;
    assign unused_trace = ^{pc_q, addr_q[31:ADDR_W]};
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed table, reset/timeout sequences, random traffic.
module tb_mem_access_unit;

    localparam int ADDR_W   = 12;
    localparam int MAX_WAIT = 255;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
    logic [1:0]        req_size = 2'd0;
    logic [31:0]       req_addr = '0, req_wdata = '0, req_pc = '0;
    logic              req_ready, rsp_valid, rsp_err, mem_req, mem_we;
    logic [31:0]       rsp_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata = '0;
    logic              mem_ack = 1'b0;

    mem_access_unit #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_pc(req_pc),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        int  addr;
        bit  we;
        int  data;
    } acc_t;

    typedef struct {
        string       name;
        logic        write;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          wait_n;
        bit          no_ack;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Memory behind the bus: only the responder touches it.
    byte unsigned dmem [4096];
    int   wait_n = 0;
    bit   no_ack = 1'b0;
    int   ack_cnt = 0;
    acc_t acc_log[$];

    // Reference memory and expected accesses: only the main process touches these.
    byte unsigned ref_mem [4096];
    acc_t exp_acc[$];

    always @(negedge clk) begin
        if (mem_req && !no_ack && ack_cnt >= wait_n) begin
            int a;
            a = int'(mem_addr);
            if (mem_we) dmem[a] = mem_wdata;
            mem_rdata = dmem[a];
            mem_ack   = 1'b1;
            acc_log.push_back('{a, mem_we, int'(dmem[a])});
            ack_cnt = 0;
        end else begin
            mem_ack = 1'b0;
            if (mem_req) ack_cnt++;
            else         ack_cnt = 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference behaviour from the access rules; fills exp_acc and updates ref_mem.
    task automatic model(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, input int wn, input bit na,
                         output logic [31:0] er, output logic ee, output int el);
        int n, base;
        logic [31:0] val;
        bit bad;
        n    = (sz == 2'd0) ? 4 : (sz == 2'd2) ? 2 : 1;
        base = int'(a % 4096);
        bad  = (sz == 2'd3) || (sz == 2'd0 && a % 4 != 0) || (sz == 2'd2 && a % 2 != 0);
        exp_acc.delete();
        er = 32'd0;
        if (bad) begin
            ee = 1'b1; el = 1;
        end else if (na) begin
            ee = 1'b1; el = 1 + MAX_WAIT;
        end else begin
            ee = 1'b0; el = 1 + n * (wn + 1);
            val = 32'd0;
            for (int k = 0; k < n; k++) begin
                int ba;
                ba = (base + k) % 4096;
                if (w) begin
                    ref_mem[ba] = byte'((wd >> (8 * k)) & 32'hFF);
                    exp_acc.push_back('{ba, 1'b1, int'(ref_mem[ba])});
                end else begin
                    val = val | (32'(ref_mem[ba]) << (8 * k));
                    exp_acc.push_back('{ba, 1'b0, 0});
                end
            end
            if (!w) begin
                if (n < 4 && sg && val[8 * n - 1]) val = val | (32'hFFFF_FFFF << (8 * n));
                er = val;
            end
        end
    endtask

    task automatic do_txn(input string nm, input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, input int wn, input bit na,
                          input logic [31:0] er, input logic ee, input int el);
        int t, lat;
        wait_n = wn;
        no_ack = na;
        acc_log.delete();
        t = 0;
        while (!req_ready && t < 20) begin @(posedge clk); #1; t++; end
        chk({nm, ".ready"}, {31'd0, req_ready}, 32'd1);
        req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_pc = 32'h0000_1000 + 32'(checks);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 400) begin @(posedge clk); #1; lat++; end
        chk({nm, ".lat"}, 32'(lat), 32'(el));
        chk({nm, ".rdata"}, rsp_rdata, er);
        chk({nm, ".err"}, {31'd0, rsp_err}, {31'd0, ee});
        @(posedge clk); #1;
        chk({nm, ".pulse"}, {31'd0, rsp_valid}, 32'd0);
        chk({nm, ".nacc"}, 32'(acc_log.size()), 32'(exp_acc.size()));
        for (int i = 0; i < exp_acc.size() && i < acc_log.size(); i++) begin
            chk($sformatf("%s.addr%0d", nm, i), 32'(acc_log[i].addr), 32'(exp_acc[i].addr));
            chk($sformatf("%s.we%0d", nm, i), {31'd0, acc_log[i].we}, {31'd0, exp_acc[i].we});
            if (exp_acc[i].we) chk($sformatf("%s.wd%0d", nm, i), 32'(acc_log[i].data), 32'(exp_acc[i].data));
        end
        $display("txn %s w=%0d sz=%0d addr=%h rdata=%h err=%0d lat=%0d", nm, w, sz, a, rsp_rdata, rsp_err, lat);
    endtask

    task automatic run_model_txn(input string nm, input logic w, input logic [1:0] sz, input logic sg,
                                 input logic [31:0] a, input logic [31:0] wd, input int wn);
        logic [31:0] er; logic ee; int el;
        model(w, sz, sg, a, wd, wn, 1'b0, er, ee, el);
        do_txn(nm, w, sz, sg, a, wd, wn, 1'b0, er, ee, el);
    endtask

    vec_t vecs[13];

    initial begin
        logic [31:0] er; logic ee; int el;
        int seen;

        vecs[0]  = '{"st_word_10",   1, 2'd0, 0, 32'h10,  32'h12345678, 0, 0, 32'h0,        0, 5};
        vecs[1]  = '{"ld_sb_13",     0, 2'd1, 1, 32'h13,  32'h0,        0, 0, 32'h00000012, 0, 2};
        vecs[2]  = '{"st_b_20",      1, 2'd1, 0, 32'h20,  32'hFFFFFF80, 0, 0, 32'h0,        0, 2};
        vecs[3]  = '{"ld_sb_20",     0, 2'd1, 1, 32'h20,  32'h0,        0, 0, 32'hFFFFFF80, 0, 2};
        vecs[4]  = '{"ld_ub_20",     0, 2'd1, 0, 32'h20,  32'h0,        0, 0, 32'h00000080, 0, 2};
        vecs[5]  = '{"ld_w_mis",     0, 2'd0, 0, 32'h12,  32'h0,        0, 0, 32'h0,        1, 1};
        vecs[6]  = '{"st_h_ffe",     1, 2'd2, 0, 32'hFFE, 32'h1234A5C3, 0, 0, 32'h0,        0, 3};
        vecs[7]  = '{"ld_uh_ffe_w2", 0, 2'd2, 0, 32'hFFE, 32'h0,        2, 0, 32'h0000A5C3, 0, 7};
        vecs[8]  = '{"ld_sh_ffe_w2", 0, 2'd2, 1, 32'hFFE, 32'h0,        2, 0, 32'hFFFFA5C3, 0, 7};
        vecs[9]  = '{"ld_rsvd",      0, 2'd3, 0, 32'h0,   32'h0,        0, 0, 32'h0,        1, 1};
        vecs[10] = '{"ld_w_10_w1",   0, 2'd0, 0, 32'h10,  32'h0,        1, 0, 32'h12345678, 0, 9};
        vecs[11] = '{"st_h_mis",     1, 2'd2, 0, 32'h11,  32'h0000BEEF, 0, 0, 32'h0,        1, 1};
        vecs[12] = '{"ld_b_timeout", 0, 2'd1, 0, 32'h40,  32'h0,        0, 1, 32'h0,        1, 1 + MAX_WAIT};

        repeat (2) @(posedge clk);
        #1;
        chk("rst.req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst.rsp_rdata", rsp_rdata, 32'd0);
        chk("rst.rsp_err",   {31'd0, rsp_err},   32'd0);
        chk("rst.mem_req",   {31'd0, mem_req},   32'd0);
        chk("rst.mem_we",    {31'd0, mem_we},    32'd0);
        chk("rst.mem_addr",  32'(mem_addr),      32'd0);
        chk("rst.mem_wdata", 32'(mem_wdata),     32'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            model(vecs[i].write, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                  vecs[i].wait_n, vecs[i].no_ack, er, ee, el);
            do_txn(vecs[i].name, vecs[i].write, vecs[i].size, vecs[i].sgn, vecs[i].addr,
                   vecs[i].wdata, vecs[i].wait_n, vecs[i].no_ack,
                   vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat);
        end
        chk("mem_10", 32'(dmem[16]), 32'h78);
        chk("mem_13", 32'(dmem[19]), 32'h12);

        // Word store at 0xFFC cut short by reset after its second byte.
        wait_n = 0; no_ack = 1'b0;
        acc_log.delete();
        req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'hFFC; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("irst.mem_req",   {31'd0, mem_req},   32'd0);
        chk("irst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("irst.mem_addr",  32'(mem_addr),      32'd0);
        ref_mem[12'hFFC] = 8'h0D;
        ref_mem[12'hFFD] = 8'hF0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        chk("irst.no_rsp",  32'(seen), 32'd0);
        chk("irst.ready",   {31'd0, req_ready}, 32'd1);
        chk("irst.nacc",    32'(acc_log.size()), 32'd2);
        $display("txn irst_store_ffc partial_bytes=%0d", acc_log.size());
        run_model_txn("ld_ub_ffd", 1'b0, 2'd1, 1'b0, 32'hFFD, 32'h0, 0);
        chk("irst.ffd", rsp_rdata, 32'h0);
        run_model_txn("ld_ub_ffe", 1'b0, 2'd1, 1'b0, 32'hFFE, 32'h0, 1);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd0) a[1:0] = 2'b00;
                if (sz == 2'd2) a[0] = 1'b0;
            end
            run_model_txn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), sz,
                          1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
